// File: rtl/pe64_index_decoder.sv
// 6-bit index -> 64-bit one-hot decoder (row/col split), 2-stage valid/ready pipe, 2-cycle latency.
// Backpressure: holds up to 2 entries; in_ready drops only with both stages full and out_ready low.
module pe64_index_decoder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ROW_BITS+COL_BITS-1:0]       in_idx,
    input  logic                               in_en,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [(2**ROW_BITS)*(2**COL_BITS)-1:0] out_onehot,
    output logic [ROW_BITS+COL_BITS-1:0]       out_idx,
    output logic                               out_en,
    output logic [(2**ROW_BITS)*(2**COL_BITS)-1:0] acc_vec,
    input  logic                               acc_clr
);

    localparam int ROWS  = 2 ** ROW_BITS;
    localparam int COLS  = 2 ** COL_BITS;
    localparam int IDX_W = ROW_BITS + COL_BITS;
    localparam int WIDTH = ROWS * COLS;

    logic             s1_valid_q, s1_valid_d;
    logic [ROWS-1:0]  s1_row_q,   s1_row_d;
    logic [COLS-1:0]  s1_col_q,   s1_col_d;
    logic [IDX_W-1:0] s1_idx_q,   s1_idx_d;
    logic             s1_en_q,    s1_en_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_vec_q,   s2_vec_d;
    logic [IDX_W-1:0] s2_idx_q,   s2_idx_d;
    logic             s2_en_q,    s2_en_d;

    logic [WIDTH-1:0] acc_q,      acc_d;

    logic s2_adv, s1_adv, in_fire, out_fire;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid & s1_adv;
    assign out_fire = s2_valid_q & out_ready;

    // Stage 1: row select is gated by in_en so a disabled entry decodes to zero downstream.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_row_d   = s1_row_q;
        s1_col_d   = s1_col_q;
        s1_idx_d   = s1_idx_q;
        s1_en_d    = s1_en_q;
        if (s1_adv) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            for (int r = 0; r < ROWS; r++) begin
                s1_row_d[r] = in_en && (in_idx[IDX_W-1:COL_BITS] == r[ROW_BITS-1:0]);
            end
            for (int c = 0; c < COLS; c++) begin
                s1_col_d[c] = (in_idx[COL_BITS-1:0] == c[COL_BITS-1:0]);
            end
            s1_idx_d = in_idx;
            s1_en_d  = in_en;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_vec_d   = s2_vec_q;
        s2_idx_d   = s2_idx_q;
        s2_en_d    = s2_en_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    s2_vec_d[r*COLS+c] = s1_row_q[r] & s1_col_q[c];
                end
            end
            s2_idx_d = s1_idx_q;
            s2_en_d  = s1_en_q;
        end
    end

    // A vector delivered alongside acc_clr is ORed in after the clear, so it survives.
    always_comb begin
        acc_d = acc_clr ? '0 : acc_q;
        if (out_fire) begin
            acc_d = acc_d | s2_vec_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_idx_q   <= '0;
            s1_en_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_vec_q   <= '0;
            s2_idx_q   <= '0;
            s2_en_q    <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_row_q   <= s1_row_d;
            s1_col_q   <= s1_col_d;
            s1_idx_q   <= s1_idx_d;
            s1_en_q    <= s1_en_d;
            s2_valid_q <= s2_valid_d;
            s2_vec_q   <= s2_vec_d;
            s2_idx_q   <= s2_idx_d;
            s2_en_q    <= s2_en_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_onehot = s2_vec_q;
    assign out_idx    = s2_idx_q;
    assign out_en     = s2_en_q;
    assign acc_vec    = acc_q;

endmodule

// File: tb/tb_pe64_index_decoder.sv
// Bench for pe64_index_decoder: in-order scoreboard of accepted indices, expected vector = 1<<idx.
module tb_pe64_index_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_en;
    logic [5:0]  in_idx;
    logic        out_valid, out_ready, out_en;
    logic [63:0] out_onehot, acc_vec;
    logic [5:0]  out_idx;
    logic        acc_clr;

    pe64_index_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_en     (out_en),
        .acc_vec    (acc_vec),
        .acc_clr    (acc_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] idx;
        logic       en;
        int         age;
    } ent_t;

    ent_t        q[$];
    logic [63:0] acc_m;
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          last_fi;

    function automatic logic [63:0] vec_of(input logic [5:0] idx, input logic en);
        return en ? (64'h1 << idx) : 64'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the pre-edge view, then apply the edge to the model and check acc_vec.
    task automatic tick();
        bit          fi, fo, exp_vld;
        logic [63:0] ev;
        #1;
        exp_vld = (q.size() > 0) && (q[0].age >= 2);
        chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
        chk("out_valid", 64'(out_valid), 64'(exp_vld));
        if (exp_vld) begin
            chk("out_onehot", out_onehot, vec_of(q[0].idx, q[0].en));
            chk("out_idx", 64'(out_idx), 64'(q[0].idx));
            chk("out_en", 64'(out_en), 64'(q[0].en));
        end
        fo = out_valid && out_ready;
        fi = in_valid && in_ready;
        @(posedge clk);
        #1;
        ev = 64'h0;
        if (fo && q.size() > 0) begin
            ev = vec_of(q[0].idx, q[0].en);
            void'(q.pop_front());
        end
        acc_m = (acc_clr ? 64'h0 : acc_m) | ev;
        foreach (q[i]) q[i].age++;
        if (fi) q.push_back('{idx: in_idx, en: in_en, age: 1});
        chk("acc_vec", acc_vec, acc_m);
        last_fi = fi;
    endtask

    task automatic send(input logic [5:0] idx, input logic en);
        in_valid = 1'b1;
        in_idx   = idx;
        in_en    = en;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_fi) break;
        end
        if (!last_fi) chk("send_timeout", 64'(last_fi), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int order[64];
        rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_en = 1'b0;
        out_ready = 1'b0; acc_clr = 1'b0; acc_m = 64'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_onehot", out_onehot, 64'h0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_en", 64'(out_en), 64'd0);
        chk("rst_acc", acc_vec, 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single beat, idx 0: visible 2 cycles after acceptance
        out_ready = 1'b1;
        send(6'd0, 1'b1);
        tick();
        chk("t1_lat_vld", 64'(out_valid), 64'd1);
        chk("t1_onehot", out_onehot, 64'h1);
        tick();
        chk("t1_acc", acc_vec, 64'h1);
        drain();

        // Back-to-back stream after clearing the accumulator
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        send(6'd63, 1'b1);
        send(6'd42, 1'b1);
        send(6'd5, 1'b1);
        drain();
        chk("t2_acc", acc_vec, 64'h8000_0400_0000_0020);

        // Stall: two beats fit, third waits until release
        out_ready = 1'b0;
        in_valid = 1'b1; in_en = 1'b1;
        in_idx = 6'd11; tick();
        in_idx = 6'd22; tick();
        in_idx = 6'd33;
        for (int k = 0; k < 4; k++) tick();
        chk("t3_stall_rdy", 64'(in_ready), 64'd0);
        chk("t3_stall_idx", 64'(out_idx), 64'd11);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // Disabled entry handshakes but decodes to zero
        send(6'd17, 1'b0);
        tick();
        chk("t4_onehot", out_onehot, 64'h0);
        chk("t4_idx", 64'(out_idx), 64'd17);
        drain();

        // Clear in the same cycle as delivery of idx 9
        out_ready = 1'b0;
        send(6'd9, 1'b1);
        for (int k = 0; k < 5 && !(q.size() > 0 && q[0].age >= 2); k++) tick();
        out_ready = 1'b1; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("t5_acc", acc_vec, 64'h200);

        // Reset with two entries in flight
        out_ready = 1'b0;
        send(6'd30, 1'b1);
        send(6'd31, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_vld", 64'(out_valid), 64'd0);
        chk("t6_rst_acc", acc_vec, 64'h0);
        q.delete(); acc_m = 64'h0;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();

        // Random sweep over a shuffled permutation of all indices
        foreach (order[i]) order[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int n = 0; n < 64; n++) begin
            in_valid = 1'b1;
            in_idx   = 6'(order[n]);
            in_en    = ($urandom_range(7, 0) != 0);
            for (int k = 0; k < 50; k++) begin
                out_ready = ($urandom_range(3, 0) != 0);
                acc_clr   = ($urandom_range(15, 0) == 0);
                tick();
                if (last_fi) break;
            end
            if (!last_fi) chk("sweep_timeout", 64'(last_fi), 64'd1);
            in_valid = ($urandom_range(1, 0) == 1) ? 1'b0 : 1'b0;
            acc_clr  = 1'b0;
            if ($urandom_range(3, 0) == 0) tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
